// File: rtl/rvsteel_reset_pkg.sv
// Shared types and constants for the rvsteel board-level reset sequencer.
package rvsteel_reset_pkg;

  typedef enum logic [1:0] {
    StPorHold     = 2'd0,
    StRun         = 2'd1,
    StButtonHeld  = 2'd2,
    StReleaseHold = 2'd3
  } seq_state_e;

  localparam int unsigned ResetCountWidth = 8;

  // Counter width able to hold values up to n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side signals of the reset sequencer: raw button/halt in, SoC controls out.
interface reset_sequencer_if;
  import rvsteel_reset_pkg::*;

  logic                       button_in;
  logic                       halt_in;
  logic                       soc_reset;
  logic                       soc_halt;
  logic                       running;
  logic [ResetCountWidth-1:0] reset_count;

  modport master (
    output button_in, halt_in,
    input  soc_reset, soc_halt, running, reset_count
  );

  modport slave (
    input  button_in, halt_in,
    output soc_reset, soc_halt, running, reset_count
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a raw button and accepts a level change only after it has been
// stable for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
  import rvsteel_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic debounced_out
);
  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync_btn;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_btn)
  );

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_btn != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign debounced_out = db_q;
endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/reset_sequencer.sv
// Holds the rvsteel SoC in reset after power-on and after each debounced button
// press/release, gates the synchronized halt switch, and counts button resets.
module reset_sequencer
  import rvsteel_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned RESET_HOLD_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  reset_sequencer_if.slave   bus
);
  localparam int unsigned HoldW = cnt_width(RESET_HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD_CYCLES - 1);

  logic btn_db;
  logic halt_sync;

  seq_state_e                 state_q, state_d;
  logic [HoldW-1:0]           hold_q, hold_d;
  logic [ResetCountWidth-1:0] count_q, count_d;
  logic                       soc_reset_q, soc_reset_d;
  logic                       soc_halt_q, soc_halt_d;
  logic                       running_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock         (clock),
    .reset         (reset),
    .raw_in        (bus.button_in),
    .debounced_out (btn_db)
  );

  sync_2ff u_halt_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.halt_in),
    .q     (halt_sync)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    unique case (state_q)
      StPorHold, StReleaseHold: begin
        // A press wins over an expiring hold so soc_reset never glitches low.
        if (btn_db) begin
          state_d = StButtonHeld;
        end else if (hold_q == HoldMax) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        if (btn_db) begin
          state_d = StButtonHeld;
          count_d = (count_q == '1) ? count_q : count_q + ResetCountWidth'(1);
        end
      end
      StButtonHeld: begin
        if (!btn_db) begin
          state_d = StReleaseHold;
          hold_d  = '0;
        end
      end
      default: state_d = StPorHold;
    endcase

    soc_reset_d = (state_d != StRun);
    soc_halt_d  = (state_d == StRun) && halt_sync;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StPorHold;
      hold_q      <= '0;
      count_q     <= '0;
      soc_reset_q <= 1'b1;
      soc_halt_q  <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      soc_reset_q <= soc_reset_d;
      soc_halt_q  <= soc_halt_d;
      running_q   <= ~soc_reset_d;
    end
  end

  assign bus.soc_reset   = soc_reset_q;
  assign bus.soc_halt    = soc_halt_q;
  assign bus.running     = running_q;
  assign bus.reset_count = count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with a behavioural model of the
// reset/hold rules, exercised by directed scenarios and random soak.
module tb_reset_sequencer;
  localparam int DB = 4;
  localparam int H  = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  reset_sequencer_if bus ();

  reset_sequencer #(
    .DEBOUNCE_CYCLES   (DB),
    .RESET_HOLD_CYCLES (H)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: btn/halt delayed 2 cycles, debounce as run length of
  // disagreement, hold as cycles remaining before the SoC may run.
  logic [1:0] m_bh, m_hh;
  logic       m_db, m_pressed, m_halt;
  int         m_run, m_left;
  logic [7:0] m_count;
  logic       nx_pressed;
  int         nx_left;
  logic [7:0] nx_count;

  always_comb begin
    nx_pressed = m_pressed;
    nx_left    = m_left;
    nx_count   = m_count;
    if (m_db) begin
      if (!m_pressed && m_left == 0) nx_count = (m_count == 8'd255) ? m_count : m_count + 8'd1;
      nx_pressed = 1'b1;
      nx_left    = 0;
    end else if (m_pressed) begin
      nx_pressed = 1'b0;
      nx_left    = H;
    end else if (m_left > 0) begin
      nx_left = m_left - 1;
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_bh <= 2'b00; m_hh <= 2'b00; m_db <= 1'b0; m_run <= 0;
      m_pressed <= 1'b0; m_left <= H; m_count <= 8'd0; m_halt <= 1'b0;
    end else begin
      m_bh <= {m_bh[0], bus.button_in};
      m_hh <= {m_hh[0], bus.halt_in};
      if (m_bh[1] != m_db) begin
        if (m_run + 1 == DB) begin
          m_db  <= ~m_db;
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      m_pressed <= nx_pressed;
      m_left    <= nx_left;
      m_count   <= nx_count;
      m_halt    <= (!nx_pressed && nx_left == 0) && m_hh[1];
    end
  end

  logic        exp_reset;
  logic [10:0] dut_v, exp_v;
  assign exp_reset = m_pressed || (m_left != 0);
  assign dut_v = {bus.soc_reset, bus.soc_halt, bus.running, bus.reset_count};
  assign exp_v = {exp_reset, m_halt, ~exp_reset, m_count};

  task automatic test_reset();
    bus.button_in = 1'b0;
    bus.halt_in   = 1'b0;
    reset = 1'b0;
    #12;
    n_vec++;
    if (dut_v !== 11'b100_0000_0000) begin
      n_err++;
      $display("FAIL reset_values got=%b want=%b", dut_v, 11'b100_0000_0000);
    end
  endtask

  task automatic test_power_on();
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock); #1;
      n_vec++;
      if (bus.soc_reset !== (e < H)) begin
        n_err++;
        $display("FAIL por_release edge=%0d got=%b want=%b", e, bus.soc_reset, e < H);
      end
      n_vec++;
      if (dut_v !== exp_v) begin
        n_err++;
        $display("FAIL por_model edge=%0d got=%b want=%b", e, dut_v, exp_v);
      end
    end
    n_vec++;
    if (bus.running !== 1'b1 || bus.reset_count !== 8'd0) begin
      n_err++;
      $display("FAIL por_running got=%b/%0d want=1/0", bus.running, bus.reset_count);
    end
  endtask

  task automatic test_glitch();
    int len;
    for (int t = 0; t < 4; t++) begin
      len = (t == 0) ? DB - 1 : $urandom_range(1, DB - 1);
      for (int c = 0; c < len + 12; c++) begin
        @(negedge clock);
        bus.button_in = (c < len);
        @(posedge clock); #1;
        n_vec++;
        if (bus.soc_reset !== 1'b0 || bus.reset_count !== 8'd0) begin
          n_err++;
          $display("FAIL glitch len=%0d got=%b/%0d want=0/0", len, bus.soc_reset, bus.reset_count);
        end
        n_vec++;
        if (dut_v !== exp_v) begin
          n_err++;
          $display("FAIL glitch_model got=%b want=%b", dut_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_full_press();
    int rise_at = -1;
    int fall_at = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      bus.button_in = (c <= 20);
      @(posedge clock); #1;
      if (rise_at < 0 && bus.soc_reset === 1'b1) rise_at = c;
      if (rise_at > 0 && fall_at < 0 && bus.soc_reset === 1'b0) fall_at = c;
      n_vec++;
      if (dut_v !== exp_v) begin
        n_err++;
        $display("FAIL press_model c=%0d got=%b want=%b", c, dut_v, exp_v);
      end
    end
    // Press sampled at edge 1: btn_db at 1+1+DB, soc_reset one edge later.
    n_vec++;
    if (rise_at !== DB + 3) begin
      n_err++;
      $display("FAIL press_rise got=%0d want=%0d", rise_at, DB + 3);
    end
    // Release sampled at edge 21: btn_db falls at 21+1+DB, then H+1 edges.
    n_vec++;
    if (fall_at !== 21 + DB + 1 + H + 1) begin
      n_err++;
      $display("FAIL press_fall got=%0d want=%0d", fall_at, 21 + DB + 1 + H + 1);
    end
    n_vec++;
    if (bus.reset_count !== 8'd1) begin
      n_err++;
      $display("FAIL press_count got=%0d want=1", bus.reset_count);
    end
  endtask

  task automatic test_repress();
    int l, rel2, rise_at;
    logic [7:0] cnt0;
    l = $urandom_range(4, 8);
    rel2 = 12 + l + 13;
    cnt0 = bus.reset_count;
    rise_at = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      bus.button_in = (c <= 12) || (c > 12 + l && c < rel2);
      @(posedge clock); #1;
      if (rise_at < 0 && bus.soc_reset === 1'b1) rise_at = c;
      if (rise_at > 0 && c <= rel2) begin
        n_vec++;
        if (bus.soc_reset !== 1'b1) begin
          n_err++;
          $display("FAIL repress_hold l=%0d c=%0d got=0 want=1", l, c);
        end
      end
      n_vec++;
      if (dut_v !== exp_v) begin
        n_err++;
        $display("FAIL repress_model c=%0d got=%b want=%b", c, dut_v, exp_v);
      end
    end
    n_vec++;
    if (bus.reset_count !== cnt0 + 8'd1 || bus.running !== 1'b1) begin
      n_err++;
      $display("FAIL repress_count got=%0d/%b want=%0d/1", bus.reset_count, bus.running,
               cnt0 + 8'd1);
    end
  endtask

  task automatic test_halt_gating();
    logic prev_rst;
    @(negedge clock);
    bus.halt_in = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clock); #1;
      n_vec++;
      if (bus.soc_halt !== (e == 3)) begin
        n_err++;
        $display("FAIL halt_latency edge=%0d got=%b want=%b", e, bus.soc_halt, e == 3);
      end
    end
    prev_rst = bus.soc_reset;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      bus.button_in = (c <= 10);
      @(posedge clock); #1;
      if (bus.soc_reset !== prev_rst) begin
        n_vec++;
        if (bus.soc_halt !== ~bus.soc_reset) begin
          n_err++;
          $display("FAIL halt_edge c=%0d rst=%b got=%b want=%b", c, bus.soc_reset,
                   bus.soc_halt, ~bus.soc_reset);
        end
      end
      prev_rst = bus.soc_reset;
      n_vec++;
      if (dut_v !== exp_v) begin
        n_err++;
        $display("FAIL halt_model c=%0d got=%b want=%b", c, dut_v, exp_v);
      end
    end
    @(negedge clock);
    bus.halt_in = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10 && m_count < 8'd4; i++) begin
      for (int c = 1; c <= 30; c++) begin
        @(negedge clock);
        bus.button_in = (c <= 8);
        @(posedge clock); #1;
        n_vec++;
        if (dut_v !== exp_v) begin
          n_err++;
          $display("FAIL async_prep_model got=%b want=%b", dut_v, exp_v);
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      bus.button_in = 1'b1;
    end
    #1;
    n_vec++;
    if (bus.reset_count !== 8'd5 || bus.soc_reset !== 1'b1) begin
      n_err++;
      $display("FAIL async_setup got=%0d/%b want=5/1", bus.reset_count, bus.soc_reset);
    end
    #1;
    reset = 1'b0;
    bus.button_in = 1'b0;
    #1;
    n_vec++;
    if (dut_v !== 11'b100_0000_0000) begin
      n_err++;
      $display("FAIL async_values got=%b want=%b", dut_v, 11'b100_0000_0000);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock); #1;
      n_vec++;
      if (bus.soc_reset !== (e < H) || dut_v !== exp_v) begin
        n_err++;
        $display("FAIL async_restart edge=%0d got=%b want_rst=%b model=%b", e, dut_v,
                 e < H, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    int c;
    for (int i = 0; i < 262; i++) begin
      for (c = 1; c <= 6; c++) begin
        @(negedge clock);
        bus.button_in = 1'b1;
        @(posedge clock);
      end
      @(negedge clock);
      bus.button_in = 1'b0;
      for (c = 0; c < 40 && !(bus.running === 1'b1 && c > 2); c++) begin
        @(posedge clock); #1;
      end
      n_vec++;
      if (bus.running !== 1'b1 || dut_v !== exp_v) begin
        n_err++;
        $display("FAIL sat_cycle i=%0d got=%b want=%b", i, dut_v, exp_v);
      end
    end
    n_vec++;
    if (bus.reset_count !== 8'd255) begin
      n_err++;
      $display("FAIL sat_count got=%0d want=255", bus.reset_count);
    end
  endtask

  task automatic test_random_soak();
    int run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (run_left == 0) begin
        bus.button_in = ~bus.button_in;
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      if ($urandom_range(0, 9) == 0) bus.halt_in = ~bus.halt_in;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (dut_v !== 11'b100_0000_0000) begin
          n_err++;
          $display("FAIL soak_async got=%b want=%b", dut_v, 11'b100_0000_0000);
        end
        @(negedge clock);
        reset = 1'b1;
      end
      @(posedge clock); #1;
      n_vec++;
      if (dut_v !== exp_v) begin
        n_err++;
        $display("FAIL soak_model c=%0d got=%b want=%b", c, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_glitch();
    test_full_press();
    test_repress();
    test_halt_gating();
    test_async_reset();
    test_saturation();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
